// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST fail logger.
package bist_pkg;

    localparam int fail_cnt_w  = 8;
    localparam int def_a_width = 4;
    localparam int def_width   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_REPORT,
        ST_FINISHED
    } state_e;

endpackage

// File: rtl/bist_fail_logger_if.sv
// Compare stream into the logger and fail-log stream out of it.
interface bist_fail_logger_if
    import bist_pkg::*;
#(
    parameter int a_width = def_a_width,
    parameter int width   = def_width
);

    logic               cmp_valid;
    logic [a_width-1:0] cmp_addr;
    logic [width-1:0]   cmp_expected;
    logic [width-1:0]   cmp_actual;
    logic               is_equal;

    logic               log_valid;
    logic [a_width-1:0] log_addr;
    logic [width-1:0]   log_syndrome;
    logic               log_ready;

    modport master (
        output cmp_valid, cmp_addr, cmp_expected, cmp_actual, is_equal, log_ready,
        input  log_valid, log_addr, log_syndrome
    );

    modport slave (
        input  cmp_valid, cmp_addr, cmp_expected, cmp_actual, is_equal, log_ready,
        output log_valid, log_addr, log_syndrome
    );

endinterface

// File: rtl/bist_fail_fifo.sv
// Synchronous FIFO holding logged failures; pointers carry an extra wrap bit.
module bist_fail_fifo #(
    parameter int depth   = 4,
    parameter int entry_w = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic [entry_w-1:0] wr_data,
    input  logic               pop,
    output logic [entry_w-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    localparam int aw    = $clog2(depth);
    localparam int ptr_w = aw + 1;

    logic [entry_w-1:0] mem_q [depth];
    logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic               wr_en;
    logic               rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[aw] != rd_ptr_q[aw]) &&
                   (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]);

    assign rd_data = mem_q[rd_ptr_q[aw-1:0]];

    always_comb begin
        wr_en    = push && !full && !flush;
        rd_en    = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + ptr_w'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + ptr_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem_q[wr_ptr_q[aw-1:0]] <= wr_data;
    end

endmodule

// File: rtl/bist_fail_logger.sv
// Counts and logs BIST compare failures during a run, then drains the log to a consumer.
//
// state       | meaning
// ST_IDLE     | waiting for start; compares ignored
// ST_CAPTURE  | counting and logging failing compares
// ST_REPORT   | presenting logged entries oldest first
// ST_FINISHED | log drained, report_done held until next start
module bist_fail_logger
    import bist_pkg::*;
#(
    parameter int a_width = def_a_width,
    parameter int width   = def_width,
    parameter int depth   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  done_in,
    bist_fail_logger_if.slave     bus,
    output logic [fail_cnt_w-1:0] fail_count,
    output logic                  overflow,
    output logic                  report_done
);

    localparam int entry_w = a_width + width;

    state_e                 state_q, state_d;
    logic [fail_cnt_w-1:0]  fail_count_q, fail_count_d;
    logic                   overflow_q, overflow_d;
    logic                   report_done_q, report_done_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_flush;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [entry_w-1:0]     fifo_wr_data;
    logic [entry_w-1:0]     fifo_rd_data;
    logic                   is_fail;

    assign is_fail      = (state_q == ST_CAPTURE) && bus.cmp_valid && !bus.is_equal;
    assign fifo_wr_data = {bus.cmp_addr, bus.cmp_expected ^ bus.cmp_actual};

    always_comb begin
        state_d      = state_q;
        fail_count_d = fail_count_q;
        overflow_d   = overflow_q;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;
        if (start) begin
            fifo_flush   = 1'b1;
            fail_count_d = '0;
            overflow_d   = 1'b0;
            state_d      = ST_CAPTURE;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    if (is_fail) begin
                        if (fail_count_q != '1) fail_count_d = fail_count_q + fail_cnt_w'(1);
                        if (fifo_full) overflow_d = 1'b1;
                        else           fifo_push  = 1'b1;
                    end
                    if (done_in) state_d = ST_REPORT;
                end
                // Empty check first: an empty log on entry finishes on the following edge.
                ST_REPORT: begin
                    if (fifo_empty)         state_d  = ST_FINISHED;
                    else if (bus.log_ready) fifo_pop = 1'b1;
                end
                ST_IDLE, ST_FINISHED: ;
                default: state_d = ST_IDLE;
            endcase
        end
        report_done_d = (state_d == ST_FINISHED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fail_count_q  <= '0;
            overflow_q    <= 1'b0;
            report_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fail_count_q  <= fail_count_d;
            overflow_q    <= overflow_d;
            report_done_q <= report_done_d;
        end
    end

    bist_fail_fifo #(
        .depth   (depth),
        .entry_w (entry_w)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.log_valid    = (state_q == ST_REPORT) && !fifo_empty;
    assign bus.log_addr     = fifo_rd_data[entry_w-1 -: a_width];
    assign bus.log_syndrome = fifo_rd_data[width-1:0];

    assign fail_count  = fail_count_q;
    assign overflow    = overflow_q;
    assign report_done = report_done_q;

endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed self-checking bench for bist_fail_logger (a_width=4, width=4, depth=4).
module tb_bist_fail_logger;
    import bist_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       done_in;
    logic [7:0] fail_count;
    logic       overflow;
    logic       report_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bist_fail_logger_if #(.a_width(4), .width(4)) bus ();

    bist_fail_logger #(
        .a_width (4),
        .width   (4),
        .depth   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .done_in     (done_in),
        .bus         (bus),
        .fail_count  (fail_count),
        .overflow    (overflow),
        .report_done (report_done)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmp(input logic v, input logic [3:0] a, input logic [3:0] e,
                           input logic [3:0] act, input logic eq);
        bus.cmp_valid    = v;
        bus.cmp_addr     = a;
        bus.cmp_expected = e;
        bus.cmp_actual   = act;
        bus.is_equal     = eq;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; done_in = 1'b0; bus.log_ready = 1'b0;
        set_cmp(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        cyc(); cyc();
        rst = 1'b0;
        n_cmp++; if (bus.log_valid !== 1'b0) begin n_err++; $display("FAIL reset_log_valid: got %b want 0", bus.log_valid); end
        n_cmp++; if (fail_count !== 8'd0) begin n_err++; $display("FAIL reset_fail_count: got %0d want 0", fail_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (report_done !== 1'b0) begin n_err++; $display("FAIL reset_report_done: got %b want 0", report_done); end
    endtask

    task automatic test_clean_run();
        logic seen = 1'b0;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            set_cmp(1'b1, 4'(i), 4'(i), 4'(i), 1'b1);
            cyc();
            if (bus.log_valid) seen = 1'b1;
        end
        set_cmp(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        done_in = 1'b1;
        cyc();
        done_in = 1'b0;
        if (bus.log_valid) seen = 1'b1;
        n_cmp++; if (report_done !== 1'b0) begin n_err++; $display("FAIL clean_report_done_early: got %b want 0", report_done); end
        cyc();
        n_cmp++; if (report_done !== 1'b1) begin n_err++; $display("FAIL clean_report_done: got %b want 1", report_done); end
        n_cmp++; if (fail_count !== 8'd0) begin n_err++; $display("FAIL clean_fail_count: got %0d want 0", fail_count); end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL clean_log_valid_seen: got %b want 0", seen); end
    endtask

    task automatic test_two_fail();
        bus.log_ready = 1'b1;
        pulse_start();
        set_cmp(1'b1, 4'h3, 4'hA, 4'h8, 1'b0); cyc();
        set_cmp(1'b1, 4'h5, 4'h7, 4'h7, 1'b1); cyc();
        set_cmp(1'b1, 4'h9, 4'h5, 4'h4, 1'b0); cyc();
        set_cmp(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        n_cmp++; if (fail_count !== 8'd2) begin n_err++; $display("FAIL two_fail_count: got %0d want 2", fail_count); end
        done_in = 1'b1;
        cyc();
        done_in = 1'b0;
        n_cmp++; if (bus.log_valid !== 1'b1) begin n_err++; $display("FAIL two_first_valid: got %b want 1", bus.log_valid); end
        n_cmp++; if (bus.log_addr !== 4'h3) begin n_err++; $display("FAIL two_first_addr: got %h want 3", bus.log_addr); end
        n_cmp++; if (bus.log_syndrome !== 4'h2) begin n_err++; $display("FAIL two_first_syn: got %h want 2", bus.log_syndrome); end
        cyc();
        n_cmp++; if (bus.log_valid !== 1'b1) begin n_err++; $display("FAIL two_second_valid: got %b want 1", bus.log_valid); end
        n_cmp++; if (bus.log_addr !== 4'h9) begin n_err++; $display("FAIL two_second_addr: got %h want 9", bus.log_addr); end
        n_cmp++; if (bus.log_syndrome !== 4'h1) begin n_err++; $display("FAIL two_second_syn: got %h want 1", bus.log_syndrome); end
        cyc();
        n_cmp++; if (bus.log_valid !== 1'b0) begin n_err++; $display("FAIL two_drained_valid: got %b want 0", bus.log_valid); end
        cyc();
        n_cmp++; if (report_done !== 1'b1) begin n_err++; $display("FAIL two_report_done: got %b want 1", report_done); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL two_overflow: got %b want 0", overflow); end
        n_cmp++; if (fail_count !== 8'd2) begin n_err++; $display("FAIL two_final_count: got %0d want 2", fail_count); end
    endtask

    task automatic test_overflow();
        bus.log_ready = 1'b0;
        pulse_start();
        for (int k = 1; k <= 6; k++) begin
            set_cmp(1'b1, 4'(k), 4'(k), 4'h0, 1'b0);
            cyc();
            if (k == 1) begin
                n_cmp++; if (fail_count !== 8'd1) begin n_err++; $display("FAIL ovf_first_count: got %0d want 1", fail_count); end
            end
        end
        set_cmp(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        n_cmp++; if (fail_count !== 8'd6) begin n_err++; $display("FAIL ovf_count: got %0d want 6", fail_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        done_in = 1'b1;
        cyc();
        done_in = 1'b0;
        for (int h = 0; h < 3; h++) begin
            n_cmp++;
            if (bus.log_valid !== 1'b1 || bus.log_addr !== 4'h1 || bus.log_syndrome !== 4'h1) begin
                n_err++;
                $display("FAIL ovf_hold_%0d: got valid=%b addr=%h syn=%h want valid=1 addr=1 syn=1",
                         h, bus.log_valid, bus.log_addr, bus.log_syndrome);
            end
            cyc();
        end
        bus.log_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (bus.log_valid !== 1'b1 || bus.log_addr !== 4'(k) || bus.log_syndrome !== 4'(k)) begin
                n_err++;
                $display("FAIL ovf_entry_%0d: got valid=%b addr=%h syn=%h want valid=1 addr=%h syn=%h",
                         k, bus.log_valid, bus.log_addr, bus.log_syndrome, 4'(k), 4'(k));
            end
            cyc();
        end
        n_cmp++; if (bus.log_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained_valid: got %b want 0", bus.log_valid); end
        bus.log_ready = 1'b0;
        cyc();
        n_cmp++; if (report_done !== 1'b1) begin n_err++; $display("FAIL ovf_report_done: got %b want 1", report_done); end
    endtask

    task automatic test_saturate();
        pulse_start();
        set_cmp(1'b1, 4'h5, 4'h3, 4'h0, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            cyc();
            if (i == 254) begin
                n_cmp++; if (fail_count !== 8'd254) begin n_err++; $display("FAIL sat_254: got %0d want 254", fail_count); end
            end
            if (i == 255) begin
                n_cmp++; if (fail_count !== 8'd255) begin n_err++; $display("FAIL sat_255: got %0d want 255", fail_count); end
            end
        end
        set_cmp(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        n_cmp++; if (fail_count !== 8'd255) begin n_err++; $display("FAIL sat_300: got %0d want 255", fail_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sat_overflow: got %b want 1", overflow); end
        pulse_start();
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL sat_restart_overflow: got %b want 0", overflow); end
        n_cmp++; if (fail_count !== 8'd0) begin n_err++; $display("FAIL sat_restart_count: got %0d want 0", fail_count); end
        done_in = 1'b1;
        cyc();
        done_in = 1'b0;
        n_cmp++; if (bus.log_valid !== 1'b0) begin n_err++; $display("FAIL sat_flushed_valid: got %b want 0", bus.log_valid); end
        cyc();
        n_cmp++; if (report_done !== 1'b1) begin n_err++; $display("FAIL sat_empty_report_done: got %b want 1", report_done); end
    endtask

    task automatic test_done_same_cycle_and_rst();
        bus.log_ready = 1'b0;
        pulse_start();
        set_cmp(1'b1, 4'h7, 4'hF, 4'h0, 1'b0);
        done_in = 1'b1;
        cyc();
        set_cmp(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        done_in = 1'b0;
        n_cmp++; if (fail_count !== 8'd1) begin n_err++; $display("FAIL same_cycle_count: got %0d want 1", fail_count); end
        n_cmp++;
        if (bus.log_valid !== 1'b1 || bus.log_addr !== 4'h7 || bus.log_syndrome !== 4'hF) begin
            n_err++;
            $display("FAIL same_cycle_entry: got valid=%b addr=%h syn=%h want valid=1 addr=7 syn=f",
                     bus.log_valid, bus.log_addr, bus.log_syndrome);
        end
        cyc();
        rst = 1'b1;
        bus.log_ready = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++; if (bus.log_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", bus.log_valid); end
        n_cmp++; if (fail_count !== 8'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", fail_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_rst_overflow: got %b want 0", overflow); end
        n_cmp++; if (report_done !== 1'b0) begin n_err++; $display("FAIL mid_rst_report_done: got %b want 0", report_done); end
        set_cmp(1'b1, 4'h2, 4'h1, 4'h0, 1'b0);
        done_in = 1'b1;
        cyc(); cyc();
        set_cmp(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        done_in = 1'b0;
        n_cmp++; if (fail_count !== 8'd0) begin n_err++; $display("FAIL idle_ignores_cmp: got %0d want 0", fail_count); end
        n_cmp++; if (report_done !== 1'b0) begin n_err++; $display("FAIL idle_ignores_done: got %b want 0", report_done); end
        bus.log_ready = 1'b0;
    endtask

    task automatic test_start_in_finished();
        bus.log_ready = 1'b1;
        pulse_start();
        set_cmp(1'b1, 4'h2, 4'h6, 4'h3, 1'b0); cyc();
        set_cmp(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        done_in = 1'b1;
        cyc();
        done_in = 1'b0;
        cyc(); cyc();
        n_cmp++; if (report_done !== 1'b1) begin n_err++; $display("FAIL fin_report_done: got %b want 1", report_done); end
        cyc();
        n_cmp++; if (report_done !== 1'b1) begin n_err++; $display("FAIL fin_report_done_hold: got %b want 1", report_done); end
        n_cmp++; if (fail_count !== 8'd1) begin n_err++; $display("FAIL fin_count: got %0d want 1", fail_count); end
        pulse_start();
        n_cmp++; if (report_done !== 1'b0) begin n_err++; $display("FAIL restart_report_done: got %b want 0", report_done); end
        n_cmp++; if (fail_count !== 8'd0) begin n_err++; $display("FAIL restart_count: got %0d want 0", fail_count); end
        bus.log_ready = 1'b0;
        set_cmp(1'b1, 4'h4, 4'h1, 4'h0, 1'b0); cyc();
        set_cmp(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        n_cmp++; if (fail_count !== 8'd1) begin n_err++; $display("FAIL restart_capture_count: got %0d want 1", fail_count); end
        done_in = 1'b1;
        cyc();
        done_in = 1'b0;
        n_cmp++;
        if (bus.log_valid !== 1'b1 || bus.log_addr !== 4'h4 || bus.log_syndrome !== 4'h1) begin
            n_err++;
            $display("FAIL restart_entry: got valid=%b addr=%h syn=%h want valid=1 addr=4 syn=1",
                     bus.log_valid, bus.log_addr, bus.log_syndrome);
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_two_fail();
        test_overflow();
        test_saturate();
        test_done_same_cycle_and_rst();
        test_start_in_finished();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bist_fail_logger.md
BIST_FAIL_LOGGER -- requirements
Module: bist_fail_logger

Interface
REQ-001 Parameter a_width, default 4: memory address width.
REQ-002 Parameter width, default 4: memory data width.
REQ-003 Parameter depth, default 4: fail-log entries; SHALL be a power of two, >= 2.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 start  in  1  one-cycle pulse marking the start of a BIST run.
REQ-007 cmp_valid  in  1  a memory read compare occurs this cycle.
REQ-008 cmp_addr  in  a_width  address of the compared read.
REQ-009 cmp_expected  in  width  expected data (data generator side).
REQ-010 cmp_actual  in  width  data read back from memory.
REQ-011 is_equal  in  1  comparator result for this compare.
REQ-012 done_in  in  1  BIST controller done, level.
REQ-013 log_valid  out  1  a logged failure is presented.
REQ-014 log_addr  out  a_width  failing address of the presented entry.
REQ-015 log_syndrome  out  width  cmp_expected XOR cmp_actual of the presented entry.
REQ-016 log_ready  in  1  consumer accepts the presented entry.
REQ-017 fail_count  out  8  total failing compares this run, saturating.
REQ-018 overflow  out  1  at least one failure was not logged because the log was full.
REQ-019 report_done  out  1  run finished and all logged entries drained.

Function
REQ-020 The FSM SHALL have states IDLE, CAPTURE, REPORT, FINISHED.
REQ-021 start SHALL, in any state, clear the log, fail_count and overflow, and enter CAPTURE next cycle; start has priority over every other event.
REQ-022 In CAPTURE, a failure SHALL be defined as cmp_valid=1 and is_equal=0; cmp_valid SHALL be ignored in all other states.
REQ-023 Each failure SHALL increment fail_count by 1, holding at 255 once reached; the new value SHALL be visible the cycle after the failure.
REQ-024 Each failure SHALL push {cmp_addr, cmp_expected XOR cmp_actual} if the log is not full; otherwise the entry SHALL be dropped and overflow SHALL set and stay set until start or rst.
REQ-025 done_in=1 in CAPTURE SHALL move the FSM to REPORT next cycle; a failure in the same cycle SHALL still be counted and logged.
REQ-026 In REPORT, log_valid SHALL equal "log not empty", and log_addr/log_syndrome SHALL show the oldest entry (FIFO order).
REQ-027 An entry SHALL pop when log_valid=1 and log_ready=1; log_valid and data SHALL stay stable while log_valid=1 and log_ready=0.
REQ-028 REPORT SHALL move to FINISHED the cycle after the log becomes empty, including immediately when the log is empty on entry.
REQ-029 In FINISHED, report_done SHALL be 1 and SHALL hold until start or rst; log_valid SHALL be 0 outside REPORT.
REQ-030 log_ready SHALL be ignored when log_valid=0.
REQ-031 All outputs SHALL be registered or driven directly from registered FIFO state; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-032 rst=1 SHALL, at the clock edge, force IDLE, empty the log, and clear fail_count, overflow, log_valid and report_done to 0, overriding start.
REQ-033 rst asserted mid-run or mid-report SHALL discard all entries; no partial pop or push SHALL occur in that cycle.

Structure
REQ-034 Shared package bist_pkg SHALL hold the state enum, the fail-count width constant (8), and the default a_width/width.
REQ-035 Storage SHALL be one sub-module, bist_fail_fifo (synchronous FIFO, parameters depth and entry width, pointers carrying one extra wrap bit, full/empty flags).
REQ-036 Total RTL SHALL be 120-400 lines.

Verification
REQ-037 Clean run: start, 16 compares all equal, done_in -> fail_count=0, log_valid never 1, report_done=1 two cycles after done_in.
REQ-038 Two failures at addr 3 (exp 4'hA, act 4'h8) and addr 9 (exp 4'h5, act 4'h4), log_ready=1 -> entries (3, 4'h2) then (9, 4'h1), fail_count=2, overflow=0.
REQ-039 Six failures with depth=4 -> first four logged in order, overflow=1, fail_count=6; hold log_ready=0 for 3 cycles -> head entry stable.
REQ-040 300 failures -> fail_count saturates at 255.
REQ-041 Failure in the same cycle as done_in -> it is logged and counted; rst asserted mid-REPORT -> all outputs 0 and IDLE the next cycle; start in FINISHED -> counters clear and CAPTURE.
